// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
//
// Walks a horizontal row of NDIG digit boxes in step with a VGA timing
// generator and tells a single shared digit renderer which digit is under
// the beam, where the beam sits inside that digit's box, and whether the
// renderer's paint output should be let through. It also owns the digit
// values: new values are captured on request and only become visible at
// the next frame boundary, so a frame never shows a half-updated number.
//
// Parameters
//   NDIG        number of digits side by side (1..8)
//   DW, DL      digit box width / height in pixels
//   GAP         horizontal distance from the last column of one box to the
//               first column of the next one (at least 1)
//   POSX, POSY  top-left pixel of digit 0
//
// Ports
//   clk         pixel clock, all state on the rising edge
//   rst         synchronous active-high reset
//   hcount      current pixel column from the timing generator
//   vcount      current pixel row from the timing generator
//   data        digit values, data[4*NDIG-1 -: 4] is digit 0 (leftmost)
//   load        one-cycle request to capture data
//   blink_mask  per-digit blink enable, bit NDIG-1 is digit 0
//   ack         one-cycle pulse when captured data becomes displayed data
//   pending     captured data is waiting for the next frame start
//   dig_hcount  column inside the active digit box
//   dig_vcount  row inside the digit box (vcount - POSY)
//   dig_value   value of the active digit
//   dig_en      qualifies the renderer's paint output
//
// All outputs describe the hcount/vcount sample of the previous clock.
//
// Optional feature: define DIGIT_SCAN_LZB_EN to blank leading zero digits
// (the rightmost digit is always shown).

module digit_scan_ctrl #(
    parameter int          NDIG = 4,
    parameter logic [10:0] DW   = 11'd50,
    parameter logic [10:0] DL   = 11'd100,
    parameter int          GAP  = 20,
    parameter logic [10:0] POSX = 11'd0,
    parameter logic [10:0] POSY = 11'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [10:0]         hcount,
    input  logic [10:0]         vcount,
    input  logic [4*NDIG-1:0]   data,
    input  logic                load,
    input  logic [NDIG-1:0]     blink_mask,
    output logic                ack,
    output logic                pending,
    output logic [10:0]         dig_hcount,
    output logic [10:0]         dig_vcount,
    output logic [3:0]          dig_value,
    output logic                dig_en
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_GAP
    } scan_state_t;

    localparam logic [2:0]  LAST_IDX = 3'(NDIG - 1);
    localparam logic [10:0] GAP_END  = 11'(GAP - 1);

    scan_state_t        state;
    scan_state_t        state_nxt;
    scan_state_t        cur_state;
    logic [10:0]        col;
    logic [10:0]        col_nxt;
    logic [10:0]        col_inc;
    logic [2:0]         idx;
    logic [2:0]         idx_nxt;
    logic [2:0]         idx_inc;
    logic [10:0]        vrel;
    logic               line_start;
    logic               frame_start;
    logic [4*NDIG-1:0]  act_data;
    logic [4*NDIG-1:0]  act_nxt;
    logic [4*NDIG-1:0]  pend_data;
    logic [5:0]         fcnt;
    logic [5:0]         fcnt_nxt;
    logic [3:0]         sel_value;
    logic               sel_blink;
    logic               blank;
    logic               en_d;
    logic [10:0]        hcnt_d;
    logic [10:0]        vcnt_d;
    logic [3:0]         value_d;
`ifdef DIGIT_SCAN_LZB_EN
    logic [NDIG-1:0]    lz_vec;
    logic               zero_run;
    logic               sel_lz;
`endif

    // Row test relies on 11-bit wrap: rows above POSY wrap to a value far
    // larger than DL, so one unsigned compare covers both bounds.
    assign vrel        = vcount - POSY;
    assign line_start  = (hcount == POSX) && (vrel <= DL);
    assign frame_start = (hcount == 11'd0) && (vcount == 11'd0);
    assign col_inc     = col + 11'd1;
    assign idx_inc     = idx + 3'd1;

    // Values and frame count as they will be after this clock; the pixel
    // sampled at frame start is already drawn with the freshly applied data.
    assign act_nxt  = (frame_start && pending) ? pend_data : act_data;
    assign fcnt_nxt = frame_start ? (fcnt + 6'd1) : fcnt;

    // Scan state register. The registered state always describes the
    // previous hcount sample, so it also drives the output decode directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            col   <= 11'd0;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic. Column 0 of every line restarts the scan, and the
    // start check is still made from that restart so that POSX = 0 works.
    // A box spans COL 0..DW; the gap spans COL 0..GAP-2, which puts each
    // box exactly DW+GAP pixels after the previous one. GAP = 1 means the
    // boxes touch and the gap state is skipped altogether.
    always_comb begin
        cur_state = (hcount == 11'd0) ? ST_IDLE : state;
        state_nxt = cur_state;
        col_nxt   = col;
        idx_nxt   = idx;
        case (cur_state)
            ST_IDLE: begin
                col_nxt = 11'd0;
                idx_nxt = 3'd0;
                if (line_start) begin
                    state_nxt = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (col == DW) begin
                    col_nxt = 11'd0;
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = 3'd0;
                    end else if (GAP == 1) begin
                        state_nxt = ST_DIGIT;
                        idx_nxt   = idx_inc;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end else begin
                    col_nxt = col_inc;
                end
            end
            ST_GAP: begin
                if (col_inc == GAP_END) begin
                    state_nxt = ST_DIGIT;
                    col_nxt   = 11'd0;
                    idx_nxt   = idx_inc;
                end else begin
                    col_nxt = col_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                col_nxt   = 11'd0;
                idx_nxt   = 3'd0;
            end
        endcase
    end

`ifdef DIGIT_SCAN_LZB_EN
    // Leading-zero detection: lz_vec[k] is set when digits 0..k are all
    // zero. The last digit is never included so a value of zero still
    // shows a single 0.
    always_comb begin
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int k = 0; k < NDIG - 1; k++) begin
            zero_run  = zero_run & (act_nxt[4*(NDIG-1-k) +: 4] == 4'd0);
            lz_vec[k] = zero_run;
        end
        sel_lz = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_nxt == 3'(k)) begin
                sel_lz = lz_vec[k];
            end
        end
    end
`endif

    // Output decode for the pixel just sampled: pick the active digit's
    // value and blink bit, then zero everything unless we are in a box.
    always_comb begin
        sel_value = 4'd0;
        sel_blink = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_nxt == 3'(k)) begin
                sel_value = act_nxt[4*(NDIG-1-k) +: 4];
                sel_blink = blink_mask[NDIG-1-k];
            end
        end
        blank = sel_blink & fcnt_nxt[5];
`ifdef DIGIT_SCAN_LZB_EN
        blank = blank | sel_lz;
`endif
        en_d    = 1'b0;
        hcnt_d  = 11'd0;
        vcnt_d  = 11'd0;
        value_d = 4'd0;
        if (state_nxt == ST_DIGIT) begin
            en_d    = ~blank;
            hcnt_d  = col_nxt;
            vcnt_d  = vrel;
            value_d = sel_value;
        end
    end

    // Data capture, frame bookkeeping and the output registers. A load that
    // lands on frame start still lets the older pending data go live; the
    // new data then waits for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_data   <= '0;
            pend_data  <= '0;
            pending    <= 1'b0;
            fcnt       <= 6'd0;
            ack        <= 1'b0;
            dig_en     <= 1'b0;
            dig_hcount <= 11'd0;
            dig_vcount <= 11'd0;
            dig_value  <= 4'd0;
        end else begin
            act_data <= act_nxt;
            fcnt     <= fcnt_nxt;
            ack      <= frame_start & pending;
            if (load) begin
                pend_data <= data;
                pending   <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
            dig_en     <= en_d;
            dig_hcount <= hcnt_d;
            dig_vcount <= vcnt_d;
            dig_value  <= value_d;
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl
//
// Directed bench for digit_scan_ctrl with default parameters. Every driven
// pixel pushes its expected outputs (from a geometric model of the digit
// row plus a model of the load/frame handshake) onto a queue, which is
// popped and compared one clock later.

module tb_digit_scan_ctrl;

    localparam int NDIG = 4;
    localparam int DW   = 50;
    localparam int DL   = 100;
    localparam int GAP  = 20;
    localparam int POSX = 0;
    localparam int POSY = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [10:0]  hcount;
    logic [10:0]  vcount;
    logic [15:0]  data;
    logic         load;
    logic [3:0]   blink_mask;
    logic         ack;
    logic         pending;
    logic [10:0]  dig_hcount;
    logic [10:0]  dig_vcount;
    logic [3:0]   dig_value;
    logic         dig_en;

    logic [28:0]  expQ[$];
    int           checks = 0;
    int           errors = 0;
    int           ackSeen = 0;
    int           blankSeen = 0;
    string        phase = "init";

    logic [15:0]  mAct;
    logic [15:0]  mPend;
    bit           mPending;
    int           mFcnt;
    bit           mLive;

    digit_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .data       (data),
        .load       (load),
        .blink_mask (blink_mask),
        .ack        (ack),
        .pending    (pending),
        .dig_hcount (dig_hcount),
        .dig_vcount (dig_vcount),
        .dig_value  (dig_value),
        .dig_en     (dig_en)
    );

    // Free-running pixel clock, 10 time units per pixel.
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Predict the outputs for one pixel sample. Boxes are placed purely by
    // geometry: box k covers columns POSX+k*(DW+GAP) .. +DW on rows that
    // started inside POSY..POSY+DL. Packed as {ack,pending,en,h,v,value}.
    task automatic predict(input logic [10:0] h, input logic [10:0] v,
                           input logic ld, input logic [15:0] d,
                           input logic r, output logic [28:0] e);
        bit   fs;
        bit   blank;
        bit   zeroRun;
        int   rel;
        int   k;
        int   c;
        logic [3:0] val;
        e = '0;
        if (r) begin
            mAct     = '0;
            mPend    = '0;
            mPending = 0;
            mFcnt    = 0;
            mLive    = 0;
            return;
        end
        fs = (h == 11'd0) && (v == 11'd0);
        e[28] = fs && mPending;
        if (fs) begin
            if (mPending) mAct = mPend;
            mFcnt    = (mFcnt + 1) % 64;
            mPending = 0;
        end
        if (ld) begin
            mPend    = d;
            mPending = 1;
        end
        e[27] = mPending;
        if (h == 11'd0) mLive = 0;
        if (int'(h) == POSX && int'(v) >= POSY && int'(v) <= POSY + DL) mLive = 1;
        if (mLive && int'(h) >= POSX) begin
            rel = int'(h) - POSX;
            k   = rel / (DW + GAP);
            c   = rel % (DW + GAP);
            if (k < NDIG && c <= DW) begin
                val   = mAct[4*(NDIG-1-k) +: 4];
                blank = blink_mask[NDIG-1-k] && (mFcnt >= 32);
`ifdef DIGIT_SCAN_LZB_EN
                zeroRun = 1;
                for (int j = 0; j <= k; j++) begin
                    if (mAct[4*(NDIG-1-j) +: 4] != 4'd0) zeroRun = 0;
                end
                if (k < NDIG - 1 && zeroRun) blank = 1;
`else
                zeroRun = 0;
`endif
                e[26]    = !blank;
                e[25:15] = 11'(c);
                e[14:4]  = 11'(int'(v) - POSY);
                e[3:0]   = val;
            end
        end
    endtask

    // Pop the oldest expectation and compare it against what the DUT shows
    // one clock after the matching sample.
    task automatic checkOutput();
        logic [28:0] obs;
        logic [28:0] exp;
        obs = {ack, pending, dig_en, dig_hcount, dig_vcount, dig_value};
        if (ack === 1'b1) ackSeen++;
        checks++;
        assert (expQ.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s scoreboard: observed empty queue, expected one entry", phase);
        end
        if (expQ.size() == 0) return;
        exp = expQ.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s h=%0d: observed ack=%b pend=%b en=%b dh=%0d dv=%0d val=%h, expected ack=%b pend=%b en=%b dh=%0d dv=%0d val=%h",
                   phase, hcount, obs[28], obs[27], obs[26], obs[25:15], obs[14:4], obs[3:0],
                   exp[28], exp[27], exp[26], exp[25:15], exp[14:4], exp[3:0]);
        end
    endtask

    // Drive one pixel sample, queue its expectation, clock it in and check.
    task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                                 input logic ld, input logic [15:0] d,
                                 input logic r);
        logic [28:0] e;
        hcount = h;
        vcount = v;
        load   = ld;
        data   = d;
        rst    = r;
        predict(h, v, ld, d, r, e);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Scan one line from column 0 up to hEnd on row v.
    task automatic scanLine(input logic [10:0] v, input int hEnd);
        for (int h = 0; h <= hEnd; h++) begin
            applyStimulus(11'(h), v, 1'b0, 16'h0000, 1'b0);
        end
    endtask

    // Count check on observed ack pulses within a phase.
    task automatic checkAckCount(input int want);
        checks++;
        assert (ackSeen === want) else begin
            errors++;
            $error("[TB] FAIL %s ack count: observed %0d, expected %0d", phase, ackSeen, want);
        end
    endtask

    // Directed sequence: reset, capture/apply, line scan geometry, latest
    // load wins, load on frame start, leading zeros, blink, mid-line reset.
    initial begin
        rst        = 1'b1;
        hcount     = '0;
        vcount     = '0;
        data       = '0;
        load       = 1'b0;
        blink_mask = 4'b0000;

        phase = "reset";
        repeat (3) applyStimulus(11'd0, 11'd0, 1'b0, 16'h0000, 1'b1);

        phase = "load_mid";
        for (int h = 0; h <= 20; h++) begin
            applyStimulus(11'(h), 11'd200, (h == 10), 16'h1234, 1'b0);
        end

        phase = "frame_ack";
        ackSeen = 0;
        scanLine(11'd0, 5);
        checkAckCount(1);

        phase = "scan_1234";
        scanLine(11'(POSY + 5), 300);

        phase = "latest_wins";
        ackSeen = 0;
        for (int h = 0; h <= 9; h++) begin
            applyStimulus(11'(h), 11'd300, (h == 3 || h == 7),
                          (h == 3) ? 16'h1111 : 16'h2222, 1'b0);
        end
        scanLine(11'd0, 3);
        scanLine(11'(POSY + 5), 300);
        checkAckCount(1);

        phase = "coincident";
        for (int h = 0; h <= 4; h++) begin
            applyStimulus(11'(h), 11'd300, (h == 2), 16'hAAAA, 1'b0);
        end
        applyStimulus(11'd0, 11'd0, 1'b1, 16'h5555, 1'b0);
        for (int h = 1; h <= 3; h++) begin
            applyStimulus(11'(h), 11'd0, 1'b0, 16'h0000, 1'b0);
        end
        scanLine(11'(POSY + 5), 300);
        phase = "coincident_next";
        scanLine(11'd0, 3);
        scanLine(11'(POSY + 5), 300);

        phase = "leading_zero";
        for (int h = 0; h <= 3; h++) begin
            applyStimulus(11'(h), 11'd300, (h == 1), 16'h0050, 1'b0);
        end
        scanLine(11'd0, 3);
        scanLine(11'(POSY + 5), 300);

        phase = "blink";
        blink_mask = 4'b0001;
        blankSeen = 0;
        for (int f = 0; f < 128; f++) begin
            scanLine(11'd0, 1);
            for (int h = 0; h <= 262; h++) begin
                applyStimulus(11'(h), 11'(POSY + 5), 1'b0, 16'h0000, 1'b0);
                if (h == 215 && dig_en === 1'b0) blankSeen++;
            end
        end
        checks++;
        assert (blankSeen === 64) else begin
            errors++;
            $error("[TB] FAIL blink frames: observed %0d blanked, expected %0d", blankSeen, 64);
        end
        blink_mask = 4'b0000;

        phase = "reset_midline";
        ackSeen = 0;
        for (int h = 0; h <= 3; h++) begin
            applyStimulus(11'(h), 11'd300, (h == 1), 16'h7777, 1'b0);
        end
        for (int h = 0; h <= 100; h++) begin
            applyStimulus(11'(h), 11'(POSY + 5), 1'b0, 16'h0000, 1'b0);
        end
        applyStimulus(11'd101, 11'(POSY + 5), 1'b0, 16'h0000, 1'b1);
        for (int h = 102; h <= 150; h++) begin
            applyStimulus(11'(h), 11'(POSY + 5), 1'b0, 16'h0000, 1'b0);
        end
        scanLine(11'd0, 3);
        scanLine(11'(POSY + 5), 300);
        checkAckCount(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
